alu_exec_unit: RTL

- Execute-stage consumer of the 3-bit ALU control code produced by the ALU control decoder.
- Latches operands, control code and shift amount under a valid/ready handshake, performs the operation, and holds result plus zero flag until downstream accepts.
- Logic ops, add, sub and compares complete in one cycle; sll/srl run iteratively, one bit per cycle, through an internal FSM.

---
 rtl/alu_exec_unit_if.sv | 29 ++
 rtl/alu_exec_unit.sv | 103 ++++++++++
 2 files changed

// File: rtl/alu_exec_unit_if.sv
// Request/response bundle for alu_exec_unit.
//   master: issues requests (in_valid, alu_ctl, op_a, op_b, shamt) and accepts
//           results (out_ready); observes in_ready, out_valid, result, zero.
//   slave : the execute unit itself (directions mirrored).
interface alu_exec_unit_if #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned SHW   = 5
);
  logic             in_valid;
  logic             in_ready;
  logic [2:0]       alu_ctl;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic [SHW-1:0]   shamt;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             zero;

  modport master (
    output in_valid, alu_ctl, op_a, op_b, shamt, out_ready,
    input  in_ready, out_valid, result, zero
  );

  modport slave (
    input  in_valid, alu_ctl, op_a, op_b, shamt, out_ready,
    output in_ready, out_valid, result, zero
  );
endinterface

// File: rtl/alu_exec_unit.sv
// Execute-stage ALU driven by the 3-bit ALU control code.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : alu_exec_unit_if slave; valid/ready request in, valid/ready result out.
// and/or/add/sub/slt/sltu resolve at the accept edge; sll/srl with a non-zero
// amount iterate one bit per cycle in StShift. The result and zero flag are held
// in StDone until downstream takes them.
module alu_exec_unit #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned SHW   = 5
) (
  input  logic           clk,
  input  logic           rst_n,
  alu_exec_unit_if.slave bus
);

  localparam logic [2:0] CtlAnd  = 3'b000;
  localparam logic [2:0] CtlOr   = 3'b001;
  localparam logic [2:0] CtlAdd  = 3'b010;
  localparam logic [2:0] CtlSll  = 3'b011;
  localparam logic [2:0] CtlSrl  = 3'b100;
  localparam logic [2:0] CtlSltu = 3'b101;
  localparam logic [2:0] CtlSub  = 3'b110;
  localparam logic [2:0] CtlSlt  = 3'b111;

  typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

  state_e           state_q;
  logic [WIDTH-1:0] acc_q;    // shift accumulator, doubles as the result register
  logic [SHW-1:0]   cnt_q;
  logic             left_q;
  logic             zero_q;

  logic             accept;
  logic             shift_iter;
  logic [WIDTH-1:0] alu_res;
  logic [WIDTH-1:0] shift_nxt;

  assign bus.in_ready  = (state_q == StIdle) || ((state_q == StDone) && bus.out_ready);
  assign accept        = bus.in_valid && bus.in_ready;
  assign bus.out_valid = (state_q == StDone);
  assign bus.result    = acc_q;
  assign bus.zero      = zero_q;

  // Shifts by a non-zero amount go through StShift; shamt==0 resolves immediately.
  assign shift_iter = ((bus.alu_ctl == CtlSll) || (bus.alu_ctl == CtlSrl)) &&
                      (bus.shamt != '0);

  assign shift_nxt = left_q ? {acc_q[WIDTH-2:0], 1'b0} : {1'b0, acc_q[WIDTH-1:1]};

  always_comb begin
    alu_res = '0;
    unique case (bus.alu_ctl)
      CtlAnd:          alu_res = bus.op_a & bus.op_b;
      CtlOr:           alu_res = bus.op_a | bus.op_b;
      CtlAdd:          alu_res = bus.op_a + bus.op_b;
      CtlSll, CtlSrl:  alu_res = bus.op_b;
      CtlSltu:         alu_res = {{(WIDTH-1){1'b0}}, (bus.op_a < bus.op_b)};
      CtlSub:          alu_res = bus.op_a - bus.op_b;
      CtlSlt:          alu_res = {{(WIDTH-1){1'b0}}, ($signed(bus.op_a) < $signed(bus.op_b))};
      default:         alu_res = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      acc_q   <= '0;
      cnt_q   <= '0;
      left_q  <= 1'b0;
      zero_q  <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle, StDone: begin
          if (accept) begin
            if (shift_iter) begin
              acc_q   <= bus.op_b;
              cnt_q   <= bus.shamt;
              left_q  <= (bus.alu_ctl == CtlSll);
              state_q <= StShift;
            end else begin
              acc_q   <= alu_res;
              zero_q  <= (alu_res == '0);
              state_q <= StDone;
            end
          end else if ((state_q == StDone) && bus.out_ready) begin
            state_q <= StIdle;
          end
        end
        StShift: begin
          acc_q <= shift_nxt;
          cnt_q <= cnt_q - SHW'(1);
          if (cnt_q == SHW'(1)) begin
            zero_q  <= (shift_nxt == '0);
            state_q <= StDone;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule
